// File: rtl/pwm_sched_pkg.sv
// Shared types for the slow-DAC PWM update scheduler.
// No logic here: channel count, value and channel types, and the grant encoding.
// Backpressure: not applicable.
package pwm_sched_pkg;

    localparam int CH_NUM = 4;
    localparam int PWM_DW = 24;

    typedef logic [1:0]        ch_t;
    typedef logic [PWM_DW-1:0] pwm_val_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_t;

endpackage

// File: rtl/pwm_slew_step.sv
// One channel's next active value: jump to target, or move one slew step toward it.
// Latency: combinational.
// Backpressure: none.
module pwm_slew_step #(
    parameter int DW = 24,
    parameter int SW = 16
) (
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] active,
    input  logic [SW-1:0] slew,
    output logic [DW-1:0] next_active,
    output logic          changed
);

    logic signed [DW:0] diff;
    logic        [DW:0] mag;
    logic      [DW-1:0] slew_w;

    // A step is only taken when |diff| > slew, so it cannot overshoot or wrap.
    always_comb begin
        diff        = $signed({1'b0, target}) - $signed({1'b0, active});
        mag         = diff[DW] ? (~diff + 1'b1) : diff;
        slew_w      = {{(DW-SW){1'b0}}, slew};
        next_active = target;
        if (slew != '0 && mag > {1'b0, slew_w}) begin
            next_active = diff[DW] ? (active - slew_w) : (active + slew_w);
        end
        changed = (next_active != active);
    end

endmodule

// File: rtl/red_pitaya_pwm_sched.sv
// Two-requester write arbiter into per-channel targets, committed atomically to PWM outputs on sync.
// Latency: req -> ack 1 cycle; sync -> pwm/commit 1 cycle; ramps take ceil(|diff|/slew) commits.
// Backpressure: a requester holds req/ch/dat until its ack pulse; hold_i defers commits.
module red_pitaya_pwm_sched
    import pwm_sched_pkg::*;
#(
    parameter int DW = 24,
    parameter int SW = 16
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          a_req_i,
    input  logic [1:0]    a_ch_i,
    input  logic [DW-1:0] a_dat_i,
    output logic          a_ack_o,
    input  logic          b_req_i,
    input  logic [1:0]    b_ch_i,
    input  logic [DW-1:0] b_dat_i,
    output logic          b_ack_o,
    input  logic          hold_i,
    input  logic [SW-1:0] slew_i,
    input  logic          sync_i,
    output logic [DW-1:0] pwm_a_o,
    output logic [DW-1:0] pwm_b_o,
    output logic [DW-1:0] pwm_c_o,
    output logic [DW-1:0] pwm_d_o,
    output logic          commit_o,
    output logic          busy_o
);

    logic [DW-1:0]     target     [CH_NUM];
    logic [DW-1:0]     active     [CH_NUM];
    logic [DW-1:0]     target_nxt [CH_NUM];
    logic [DW-1:0]     active_nxt [CH_NUM];
    logic [DW-1:0]     step_val   [CH_NUM];
    logic [CH_NUM-1:0] step_chg;
    gnt_t              last_grant;

    logic a_elig, b_elig, a_win, b_win;
    logic commit_en, any_chg, busy_nxt;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pwm_slew_step #(.DW(DW), .SW(SW)) u_step (
            .target      (target[g]),
            .active      (active[g]),
            .slew        (slew_i),
            .next_active (step_val[g]),
            .changed     (step_chg[g])
        );
    end

    // Slew steps see the pre-write targets, so a write on the sync edge waits for the next sync.
    always_comb begin
        a_elig    = a_req_i & ~a_ack_o;
        b_elig    = b_req_i & ~b_ack_o;
        a_win     = a_elig & (~b_elig | (last_grant == GNT_B));
        b_win     = b_elig & ~a_win;
        commit_en = sync_i & ~hold_i;
        any_chg   = 1'b0;
        busy_nxt  = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            target_nxt[i] = target[i];
            if (a_win && a_ch_i == ch_t'(i)) begin
                target_nxt[i] = a_dat_i;
            end else if (b_win && b_ch_i == ch_t'(i)) begin
                target_nxt[i] = b_dat_i;
            end
            active_nxt[i] = commit_en ? step_val[i] : active[i];
            any_chg       = any_chg | (commit_en & step_chg[i]);
            busy_nxt      = busy_nxt | (active_nxt[i] != target_nxt[i]);
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int i = 0; i < CH_NUM; i++) begin
                target[i] <= '0;
                active[i] <= '0;
            end
            last_grant <= GNT_B;
            a_ack_o    <= 1'b0;
            b_ack_o    <= 1'b0;
            commit_o   <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                target[i] <= target_nxt[i];
                active[i] <= active_nxt[i];
            end
            if (a_win) begin
                last_grant <= GNT_A;
            end else if (b_win) begin
                last_grant <= GNT_B;
            end
            a_ack_o  <= a_win;
            b_ack_o  <= b_win;
            commit_o <= any_chg;
            busy_o   <= busy_nxt;
        end
    end

    assign pwm_a_o = active[0];
    assign pwm_b_o = active[1];
    assign pwm_c_o = active[2];
    assign pwm_d_o = active[3];

endmodule

// File: tb/tb_red_pitaya_pwm_sched.sv
// Bench for red_pitaya_pwm_sched: directed scenarios plus a randomized run against a reference model.
module tb_red_pitaya_pwm_sched;

    localparam int DW = 24;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req, b_req, hold, sync;
    logic [1:0]    a_ch, b_ch;
    logic [DW-1:0] a_dat, b_dat;
    logic [SW-1:0] slew;
    logic          a_ack, b_ack, commit, busy;
    logic [DW-1:0] pwm_a, pwm_b, pwm_c, pwm_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    red_pitaya_pwm_sched #(.DW(DW), .SW(SW)) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rstn),
        .a_req_i    (a_req),
        .a_ch_i     (a_ch),
        .a_dat_i    (a_dat),
        .a_ack_o    (a_ack),
        .b_req_i    (b_req),
        .b_ch_i     (b_ch),
        .b_dat_i    (b_dat),
        .b_ack_o    (b_ack),
        .hold_i     (hold),
        .slew_i     (slew),
        .sync_i     (sync),
        .pwm_a_o    (pwm_a),
        .pwm_b_o    (pwm_b),
        .pwm_c_o    (pwm_c),
        .pwm_d_o    (pwm_d),
        .commit_o   (commit),
        .busy_o     (busy)
    );

    // Reference model: values per channel, round-robin preference and ack pulses.
    logic [DW-1:0] m_tgt [4];
    logic [DW-1:0] m_act [4];
    logic [DW-1:0] n_tgt [4];
    logic [DW-1:0] n_act [4];
    logic m_prefer_a, m_aack, m_back, m_commit, m_busy;
    logic n_prefer_a, n_aack, n_back, n_commit, n_busy;

    function automatic logic [DW-1:0] ramp(input logic [DW-1:0] t, input logic [DW-1:0] a,
                                           input logic [SW-1:0] s);
        longint d, r;
        logic [63:0] rv;
        d = longint'(t) - longint'(a);
        if (s == 0 || (d < 0 ? -d : d) <= longint'(s)) return t;
        r = (d > 0) ? longint'(a) + longint'(s) : longint'(a) - longint'(s);
        if (r < 0) r = 0;
        if (r > (longint'(1) << DW) - 1) r = (longint'(1) << DW) - 1;
        rv = 64'(r);
        return rv[DW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = '0;
            m_act[i] = '0;
        end
        m_prefer_a = 1'b1;
        m_aack = 1'b0; m_back = 1'b0; m_commit = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_next();
        logic a_want, b_want;
        a_want = a_req && !m_aack;
        b_want = b_req && !m_back;
        n_aack = a_want && (!b_want || m_prefer_a);
        n_back = b_want && !n_aack;
        n_prefer_a = n_aack ? 1'b0 : (n_back ? 1'b1 : m_prefer_a);
        n_commit = 1'b0;
        n_busy   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tgt[i] = m_tgt[i];
            n_act[i] = (sync && !hold) ? ramp(m_tgt[i], m_act[i], slew) : m_act[i];
            if (n_act[i] != m_act[i]) n_commit = 1'b1;
        end
        if (n_aack) n_tgt[a_ch] = a_dat;
        if (n_back) n_tgt[b_ch] = b_dat;
        for (int i = 0; i < 4; i++) if (n_act[i] != n_tgt[i]) n_busy = 1'b1;
    endtask

    // One clock: model advances with the DUT; returns at the negedge, where inputs change.
    task automatic cyc();
        model_next();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = n_tgt[i];
            m_act[i] = n_act[i];
        end
        m_prefer_a = n_prefer_a; m_aack = n_aack; m_back = n_back;
        m_commit = n_commit; m_busy = n_busy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_req = 0; b_req = 0; a_ch = 0; b_ch = 0; a_dat = 0; b_dat = 0;
        hold = 0; sync = 0; slew = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({pwm_a, pwm_b, pwm_c, pwm_d} !== '0) begin
            n_fail++; $display("FAIL reset_pwm: got %h %h %h %h want all 0", pwm_a, pwm_b, pwm_c, pwm_d);
        end
        n_tests++;
        if ({a_ack, b_ack, commit, busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {a_ack, b_ack, commit, busy});
        end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single_write();
        a_req = 1; a_ch = 2; a_dat = 24'h9C0000;
        cyc();
        a_req = 0;
        n_tests++;
        if (a_ack !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_ack_busy: got ack=%b busy=%b want 1 1", a_ack, busy);
        end
        cyc();
        n_tests++;
        if (a_ack !== 1'b0) begin
            n_fail++; $display("FAIL single_ack_pulse: got %b want 0", a_ack);
        end
        sync = 1;
        cyc();
        sync = 0;
        n_tests++;
        if (pwm_c !== 24'h9C0000 || commit !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_commit: got pwm_c=%h commit=%b busy=%b want 9c0000 1 0",
                               pwm_c, commit, busy);
        end
        cyc();
        n_tests++;
        if (commit !== 1'b0) begin
            n_fail++; $display("FAIL single_commit_pulse: got %b want 0", commit);
        end
    endtask

    task automatic test_contention();
        logic prev_a;
        a_req = 1; a_ch = 0; a_dat = 24'd1;
        b_req = 1; b_ch = 0; b_dat = 24'd2;
        prev_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++;
            if (a_ack !== (i % 2 == 1) || b_ack !== (i % 2 == 0) || a_ack !== m_aack) begin
                n_fail++; $display("FAIL contention_grant%0d: got a=%b b=%b want a=%b b=%b",
                                   i, a_ack, b_ack, i % 2 == 1, i % 2 == 0);
            end
            n_tests++;
            if (a_ack === prev_a) begin
                n_fail++; $display("FAIL contention_alternate%0d: got a_ack=%b twice in a row", i, a_ack);
            end
            prev_a = a_ack;
        end
        a_req = 0; b_req = 0; sync = 1;
        cyc();
        sync = 0;
        n_tests++;
        if (pwm_a !== 24'd1 || pwm_a !== m_act[0]) begin
            n_fail++; $display("FAIL contention_last_wins: got %h want 000001", pwm_a);
        end
        cyc();
    endtask

    task automatic test_hold();
        hold = 1;
        b_req = 1; b_ch = 1; b_dat = 24'h100000;
        cyc();
        b_req = 0;
        n_tests++;
        if (b_ack !== 1'b1) begin
            n_fail++; $display("FAIL hold_ack: got %b want 1", b_ack);
        end
        for (int k = 0; k < 3; k++) begin
            sync = 1;
            cyc();
            sync = 0;
            n_tests++;
            if (pwm_b !== 24'h0 || commit !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL hold_sync%0d: got pwm_b=%h commit=%b busy=%b want 000000 0 1",
                                   k, pwm_b, commit, busy);
            end
            cyc();
        end
        hold = 0; sync = 1;
        cyc();
        sync = 0;
        n_tests++;
        if (pwm_b !== 24'h100000 || commit !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: got pwm_b=%h commit=%b want 100000 1", pwm_b, commit);
        end
        cyc();
    endtask

    task automatic test_slew();
        logic [DW-1:0] exp_d [12];
        logic [DW-1:0] wr_val;
        exp_d = '{24'h004000, 24'h008000, 24'h00C000, 24'h010000,
                  24'h00C000, 24'h008000, 24'h004000, 24'h000000,
                  24'h004000, 24'h006000, 24'h002000, 24'h000000};
        slew = 16'h4000;
        for (int k = 0; k < 12; k++) begin
            if (k == 0 || k == 4 || k == 8 || k == 10) begin
                wr_val = (k == 0) ? 24'h010000 : (k == 8) ? 24'h006000 : 24'h0;
                a_req = 1; a_ch = 3; a_dat = wr_val;
                cyc();
                a_req = 0;
            end
            sync = 1;
            cyc();
            sync = 0;
            n_tests++;
            if (pwm_d !== exp_d[k] || commit !== 1'b1) begin
                n_fail++; $display("FAIL slew_step%0d: got pwm_d=%h commit=%b want %h 1",
                                   k, pwm_d, commit, exp_d[k]);
            end
            n_tests++;
            if (busy !== (k != 3 && k != 7 && k != 9 && k != 11)) begin
                n_fail++; $display("FAIL slew_busy%0d: got %b", k, busy);
            end
        end
        slew = 0;
        cyc();
    endtask

    task automatic test_same_edge();
        a_req = 1; a_ch = 0; a_dat = 24'd5; sync = 1;
        cyc();
        a_req = 0; sync = 0;
        n_tests++;
        if (a_ack !== 1'b1 || pwm_a !== 24'd1 || commit !== 1'b0) begin
            n_fail++; $display("FAIL same_edge_old: got ack=%b pwm_a=%h commit=%b want 1 000001 0",
                               a_ack, pwm_a, commit);
        end
        cyc();
        sync = 1;
        cyc();
        sync = 0;
        n_tests++;
        if (pwm_a !== 24'd5 || commit !== 1'b1) begin
            n_fail++; $display("FAIL same_edge_next: got pwm_a=%h commit=%b want 000005 1", pwm_a, commit);
        end
        cyc();
    endtask

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (!a_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    a_req = 1; a_ch = 2'($urandom_range(0, 3)); a_dat = rnd_val();
                end
            end else if (m_aack) begin
                if ($urandom_range(0, 1) == 0) a_req = 0;
                else begin a_ch = 2'($urandom_range(0, 3)); a_dat = rnd_val(); end
            end
            if (!b_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_req = 1; b_ch = 2'($urandom_range(0, 3)); b_dat = rnd_val();
                end
            end else if (m_back) begin
                if ($urandom_range(0, 1) == 0) b_req = 0;
                else begin b_ch = 2'($urandom_range(0, 3)); b_dat = rnd_val(); end
            end
            sync = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 2))
                    0:       slew = '0;
                    1:       slew = SW'($urandom_range(1, 255));
                    default: slew = SW'($urandom);
                endcase
            end
            cyc();
            n_tests++;
            if ({pwm_d, pwm_c, pwm_b, pwm_a} !== {m_act[3], m_act[2], m_act[1], m_act[0]}) begin
                n_fail++; $display("FAIL rand_pwm c%0d: got %h %h %h %h want %h %h %h %h", c,
                                   pwm_a, pwm_b, pwm_c, pwm_d, m_act[0], m_act[1], m_act[2], m_act[3]);
            end
            n_tests++;
            if ({a_ack, b_ack} !== {m_aack, m_back}) begin
                n_fail++; $display("FAIL rand_ack c%0d: got %b%b want %b%b", c, a_ack, b_ack, m_aack, m_back);
            end
            n_tests++;
            if (commit !== m_commit || busy !== m_busy) begin
                n_fail++; $display("FAIL rand_flags c%0d: got commit=%b busy=%b want %b %b",
                                   c, commit, busy, m_commit, m_busy);
            end
        end
        a_req = 0; b_req = 0; sync = 0; hold = 0;
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid_ramp();
        slew = 16'h1000;
        b_req = 1; b_ch = 1; b_dat = 24'h800000;
        cyc();
        b_req = 0;
        repeat (3) begin
            sync = 1; cyc(); sync = 0; cyc();
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_ramp_busy: got %b want 1", busy);
        end
        a_req = 1; a_ch = 0; a_dat = 24'h123456;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({pwm_a, pwm_b, pwm_c, pwm_d} !== '0 || {a_ack, b_ack, commit, busy} !== 4'b0) begin
            n_fail++; $display("FAIL async_reset: got pwm %h %h %h %h flags %b want all 0",
                               pwm_a, pwm_b, pwm_c, pwm_d, {a_ack, b_ack, commit, busy});
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_held_ack: got %b want 0", a_ack);
        end
        rstn = 1'b1;
        cyc();
        a_req = 0;
        n_tests++;
        if (a_ack !== 1'b1 || busy !== 1'b1 || pwm_b !== 24'h0) begin
            n_fail++; $display("FAIL post_reset_ack: got ack=%b busy=%b pwm_b=%h want 1 1 000000",
                               a_ack, busy, pwm_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_hold();
        test_slew();
        test_same_edge();
        test_random();
        test_reset_mid_ramp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
